// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage
// Registered RV32I decode stage sitting between fetch and execute.
//
// An instruction accepted on the input handshake is decoded combinationally
// and captured either into the main output register or, when execute is
// stalling, into a one-entry skid register. in_ready is a flop, so fetch
// never sees a combinational path from out_ready.
//
// Ports:
//   CLK, RESETn       clock, synchronous active-low reset
//   flush             drops every held entry (and any same-cycle input)
//   in_valid/in_ready fetch-side handshake; in_instr / in_pc payload
//   out_valid/out_ready execute-side handshake
//   out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_ctrl, out_alu_src,
//   out_reg_w, out_mem_w, out_mem_to_reg, out_branch, out_jump,
//   out_funct3, out_illegal   decoded entry fields
//
// Build option:
//   RV32M_EN  when defined, funct7=0x01 on OP decodes the M extension
//             (alu_ctrl 16..23); otherwise those encodings are illegal.
//
// Register index and funct3 fields are always passed through raw from the
// instruction word, whether or not the format uses them.
module rv32_decode_stage #(
  parameter int PC_W   = 32,
  parameter int ALUC_W = 5
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [31:0]       out_imm,
  output logic [ALUC_W-1:0] out_alu_ctrl,
  output logic              out_alu_src,
  output logic              out_reg_w,
  output logic              out_mem_w,
  output logic              out_mem_to_reg,
  output logic              out_branch,
  output logic              out_jump,
  output logic [2:0]        out_funct3,
  output logic              out_illegal
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_XOR = 5'd2, ALU_OR = 5'd3,
    ALU_AND = 5'd4, ALU_SLL = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_SLT = 5'd8, ALU_SLTU = 5'd9, ALU_PASS_B = 5'd10
  } alu_op_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic [ALUC_W-1:0] alu_ctrl;
    logic              alu_src;
    logic              reg_w;
    logic              mem_w;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
    logic [2:0]        funct3;
    logic              illegal;
  } entry_t;

  // Shared by OP and OP-IMM: funct3 selects the operation, alt picks
  // SUB over ADD and SRA over SRL.
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  alu_code;
  logic        illegal;
  entry_t      dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    dec          = '0;
    alu_code     = ALU_ADD;
    illegal      = 1'b0;
    dec.pc       = in_pc;
    dec.rd       = in_instr[11:7];
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.funct3   = funct3;

    case (opcode)
      OP_REG: begin
        dec.reg_w = 1'b1;
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)))
          alu_code = alu_op(funct3, funct7[5]);
`ifdef RV32M_EN
        else if (funct7 == 7'h01)
          alu_code = {2'b10, funct3};  // MUL..REMU map to 16..23
`endif
        else
          illegal = 1'b1;
      end
      OP_IMM: begin
        dec.reg_w   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_i;
        // Only the shift forms carry a funct7 in imm[11:5].
        alu_code = alu_op(funct3, funct3 == 3'd5 && funct7[5]);
        illegal  = (funct3 == 3'd1 && funct7 != 7'h00) ||
                   (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
      end
      OP_LOAD: begin
        dec.reg_w      = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.imm        = imm_i;
      end
      OP_STORE: begin
        dec.mem_w   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_s;
      end
      OP_BRANCH: begin
        // alu_src stays 0: rs2 is the compare operand; ADD is for the target.
        dec.branch = 1'b1;
        dec.imm    = imm_b;
      end
      OP_JAL: begin
        dec.jump    = 1'b1;
        dec.reg_w   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_j;
      end
      OP_JALR: begin
        dec.jump    = 1'b1;
        dec.reg_w   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_i;
      end
      OP_LUI: begin
        dec.reg_w   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_u;
        alu_code    = ALU_PASS_B;
      end
      OP_AUIPC: begin
        dec.reg_w   = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm     = imm_u;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      dec.reg_w  = 1'b0;
      dec.mem_w  = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_w = 1'b0;
    dec.illegal  = illegal;
    dec.alu_ctrl = ALUC_W'(alu_code);
  end

  state_t state;
  entry_t main_q, skid_q;
  logic   in_hs, out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!RESETn) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      main_q    <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: if (in_hs) begin
          main_q    <= dec;
          out_valid <= 1'b1;
          state     <= S_ONE;
        end
        S_ONE: begin
          if (in_hs && out_hs) begin
            main_q <= dec;
          end else if (in_hs) begin
            in_ready <= 1'b0;
            state    <= S_TWO;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end
        end
        S_TWO: if (out_hs) begin
          main_q   <= skid_q;
          in_ready <= 1'b1;
          state    <= S_ONE;
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: the skid register has no reset; it is only ever read after being
  // written in the same ONE->TWO transition that marks it valid.
  always_ff @(posedge CLK) begin
    if (state == S_ONE && in_hs && !out_hs) skid_q <= dec;
  end

  assign out_pc         = main_q.pc;
  assign out_rd         = main_q.rd;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_imm        = main_q.imm;
  assign out_alu_ctrl   = main_q.alu_ctrl;
  assign out_alu_src    = main_q.alu_src;
  assign out_reg_w      = main_q.reg_w;
  assign out_mem_w      = main_q.mem_w;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_branch     = main_q.branch;
  assign out_jump       = main_q.jump;
  assign out_funct3     = main_q.funct3;
  assign out_illegal    = main_q.illegal;

endmodule
